// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU.
// Optional WAIT watchdog: define ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  x0,
    input  logic [7:0]  y0,
    input  logic [7:0]  adiv0,
    input  logic [2:0]  op0,
    input  logic [7:0]  x1,
    input  logic [7:0]  y1,
    input  logic [7:0]  adiv1,
    input  logic [2:0]  op1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] result0,
    output logic [15:0] result1,
    output logic        err0,
    output logic        err1,
    output logic        busy,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    output logic [7:0]  alu_adiv,
    output logic [2:0]  alu_op,
    output logic        alu_begin,
    input  logic        alu_end,
    input  logic [15:0] alu_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state;
    state_t state_nxt;
    logic   ptr;
    logic   win;
    logic   pick;
    logic   fin;
    logic   tmo;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be 1..255");
    end

    // Pointer only matters when both request; a lone requester always wins.
    assign pick = (req0 && req1) ? ptr : req1;

`ifdef ALU_ARB_TIMEOUT_EN
    logic [7:0] cnt;
    logic       err_q;

    assign tmo = (state == WAIT) && !alu_end &&
                 (cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    assign fin = (state == WAIT) && (alu_end || tmo);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (fin) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr      <= 1'b0;
            win      <= 1'b0;
            alu_x    <= 8'h00;
            alu_y    <= 8'h00;
            alu_adiv <= 8'h00;
            alu_op   <= 3'b000;
            result0  <= 16'h0000;
            result1  <= 16'h0000;
        end else begin
            if (state == IDLE && (req0 || req1)) begin
                win      <= pick;
                alu_x    <= pick ? x1 : x0;
                alu_y    <= pick ? y1 : y0;
                alu_adiv <= pick ? adiv1 : adiv0;
                alu_op   <= pick ? op1 : op0;
            end
            if (fin) begin
                if (win) begin
                    result1 <= tmo ? 16'hFFFF : alu_out;
                end else begin
                    result0 <= tmo ? 16'hFFFF : alu_out;
                end
            end
            if (state == DONE) begin
                ptr <= ~win;
            end
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= 8'h00;
            err_q <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                cnt <= 8'h00;
            end else if (state == WAIT && !alu_end) begin
                cnt <= cnt + 8'h01;
            end
            if (fin) begin
                err_q <= tmo;
            end
        end
    end
`endif

    always_comb begin
        busy      = (state != IDLE);
        alu_begin = (state == ISSUE);
        gnt0      = alu_begin && !win;
        gnt1      = alu_begin && win;
        done0     = (state == DONE) && !win;
        done1     = (state == DONE) && win;
`ifdef ALU_ARB_TIMEOUT_EN
        err0      = done0 && err_q;
        err1      = done1 && err_q;
`else
        err0      = 1'b0;
        err1      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural multi-cycle ALU.
// Define ALU_ARB_TIMEOUT_EN to exercise the watchdog build.
module tb_alu_arbiter;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 64;
`endif

    logic        clk;
    logic        resetn;
    logic        req0, req1;
    logic [7:0]  x0, y0, adiv0, x1, y1, adiv1;
    logic [2:0]  op0, op1;
    logic        gnt0, gnt1, done0, done1, err0, err1, busy;
    logic [15:0] result0, result1;
    logic [7:0]  alu_x, alu_y, alu_adiv;
    logic [2:0]  alu_op;
    logic        alu_begin, alu_end;
    logic [15:0] alu_out;
    logic        alu_end_m, alu_end_s;
    logic [15:0] alu_out_m;

    typedef struct packed {
        logic        idx;
        logic [15:0] res;
        logic        err;
    } done_t;

    done_t       done_q[$];
    logic        gnt_q[$];
    logic [15:0] shadow[2];
    int          total, bad;
    int          begins, alu_lat;
    int          cyc, gnt_cyc, last_dur;
    logic [15:0] model_r;
    logic [7:0]  model_x, model_y;

    alu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .req0(req0), .req1(req1),
        .x0(x0), .y0(y0), .adiv0(adiv0), .op0(op0),
        .x1(x1), .y1(y1), .adiv1(adiv1), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result0(result0), .result1(result1),
        .err0(err0), .err1(err1), .busy(busy),
        .alu_x(alu_x), .alu_y(alu_y), .alu_adiv(alu_adiv),
        .alu_op(alu_op), .alu_begin(alu_begin),
        .alu_end(alu_end), .alu_out(alu_out)
    );

    assign alu_end = alu_end_m | alu_end_s;
    assign alu_out = alu_out_m;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic exp_done(input logic i, input logic [15:0] r,
                            input logic e);
        done_t d;
        d.idx = i;
        d.res = r;
        d.err = e;
        done_q.push_back(d);
    endtask

    // ALU model: op 0 multiplies, anything else concatenates x:y.
    initial begin
        alu_end_m = 1'b0;
        alu_out_m = 16'h0000;
        forever begin
            @(negedge clk);
            if (alu_begin && alu_lat != 0) begin
                model_x = alu_x;
                model_y = alu_y;
                if (alu_op == 3'b000)
                    model_r = {8'h00, alu_x} * {8'h00, alu_y};
                else
                    model_r = {alu_x, alu_y};
                repeat (alu_lat) @(negedge clk);
                if (busy) begin
                    check("operand_hold", {alu_x, alu_y},
                          {model_x, model_y});
                end
                alu_end_m = 1'b1;
                alu_out_m = model_r;
                @(negedge clk);
                alu_end_m = 1'b0;
                alu_out_m = 16'h0000;
            end
        end
    end

    initial begin
        done_t d;
        logic  g;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (alu_begin) begins++;
            if (gnt0 || gnt1) begin
                gnt_cyc = cyc;
                if (gnt_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_gnt: got %b%b want none",
                             gnt1, gnt0);
                end else begin
                    g = gnt_q.pop_front();
                    check("gnt_idx", gnt1, g);
                    check("gnt_onehot", gnt0 & gnt1, 0);
                end
            end
            if (done0 || done1) begin
                last_dur = cyc - gnt_cyc;
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got %b%b want none",
                             done1, done0);
                end else begin
                    d = done_q.pop_front();
                    check("done_idx", done1, d.idx);
                    check("done_onehot", done0 & done1, 0);
                    check("result", d.idx ? result1 : result0, d.res);
                    check("err", d.idx ? err1 : err0, d.err);
                    shadow[d.idx] = d.res;
                    check("other_result", d.idx ? result0 : result1,
                          shadow[!d.idx]);
                end
            end
        end
    end

    task automatic request(input logic i, input logic [7:0] x,
                           input logic [7:0] y, input logic [7:0] a,
                           input logic [2:0] op, input int lat);
        int n;
        alu_lat = lat;
        if (i) begin
            x1 = x; y1 = y; adiv1 = a; op1 = op; req1 = 1'b1;
        end else begin
            x0 = x; y0 = y; adiv0 = a; op0 = op; req0 = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(i ? gnt1 : gnt0) && n < 20);
        check("gnt_seen", i ? gnt1 : gnt0, 1);
        check("begin_with_gnt", alu_begin, 1);
        check("alu_operands", {alu_x, alu_y, alu_adiv, 5'b0, alu_op},
              {x, y, a, 5'b0, op});
        if (i) req1 = 1'b0;
        else req0 = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((done_q.size() != 0 || gnt_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", done_q.size() + gnt_q.size(), 0);
        done_q.delete();
        gnt_q.delete();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        shadow[0] = 16'h0000;
        shadow[1] = 16'h0000;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int ng;
        total = 0; bad = 0; begins = 0; alu_lat = 0;
        gnt_cyc = 0; last_dur = 0;
        resetn = 1'b0; alu_end_s = 1'b0;
        req0 = 0; req1 = 0;
        x0 = 0; y0 = 0; adiv0 = 0; op0 = 0;
        x1 = 0; y1 = 0; adiv1 = 0; op1 = 0;
        shadow[0] = 16'h0000;
        shadow[1] = 16'h0000;
        repeat (3) @(negedge clk);

        check("rst_ctrl", {busy, gnt0, gnt1, done0, done1, err0, err1,
                           alu_begin}, 0);
        check("rst_ops", {alu_x, alu_y, alu_adiv, 5'b0, alu_op}, 0);
        check("rst_results", {result1, result0}, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Stray alu_end in IDLE.
        alu_end_s = 1'b1;
        @(negedge clk);
        alu_end_s = 1'b0;
        check("idle_stray_busy", busy, 0);
        check("idle_stray_done", {done1, done0}, 0);

        // Single requester 0: 12 * 3.
        begins = 0;
        gnt_q.push_back(1'b0);
        exp_done(1'b0, 16'h0024, 1'b0);
        request(1'b0, 8'd12, 8'd3, 8'h09, 3'b000, 5);
        drain(20);
        check("latency_5", last_dur, 6);
        check("begin_count", begins, 1);
        check("result1_untouched", result1, 16'h0000);

        // Both requesting from reset: 0, 1, 0.
        pulse_reset();
        alu_lat = 2;
        x0 = 8'h11; y0 = 8'h22; adiv0 = 8'h01; op0 = 3'b001;
        x1 = 8'hAB; y1 = 8'hCD; adiv1 = 8'h02; op1 = 3'b010;
        gnt_q.push_back(1'b0);
        gnt_q.push_back(1'b1);
        gnt_q.push_back(1'b0);
        exp_done(1'b0, 16'h1122, 1'b0);
        exp_done(1'b1, 16'hABCD, 1'b0);
        exp_done(1'b0, 16'h1122, 1'b0);
        req0 = 1'b1;
        req1 = 1'b1;
        ng = 0;
        for (int k = 0; k < 60 && ng < 3; k++) begin
            @(negedge clk);
            if (gnt0 || gnt1) ng++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        drain(30);

        // Stray alu_end during ISSUE must not finish early.
        alu_lat = 4;
        x1 = 8'd2; y1 = 8'd7; adiv1 = 8'h00; op1 = 3'b000;
        gnt_q.push_back(1'b1);
        exp_done(1'b1, 16'h000E, 1'b0);
        req1 = 1'b1;
        for (int k = 0; k < 20 && !gnt1; k++) @(negedge clk);
        alu_end_s = 1'b1;
        req1 = 1'b0;
        @(negedge clk);
        alu_end_s = 1'b0;
        check("issue_stray_done", {done1, done0}, 0);
        check("issue_stray_busy", busy, 1);
        drain(20);
        check("latency_4", last_dur, 5);

        // Reset during WAIT abandons the operation.
        gnt_q.push_back(1'b0);
        request(1'b0, 8'h33, 8'h44, 8'h55, 3'b001, 10);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        shadow[0] = 16'h0000;
        shadow[1] = 16'h0000;
        #1;
        check("midrst_ctrl", {busy, gnt0, gnt1, done0, done1, err0, err1,
                              alu_begin}, 0);
        check("midrst_ops", {alu_x, alu_y, alu_adiv, 5'b0, alu_op}, 0);
        check("midrst_results", {result1, result0}, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_idle", busy, 0);
        gnt_q.push_back(1'b1);
        exp_done(1'b1, 16'h001E, 1'b0);
        request(1'b1, 8'd5, 8'd6, 8'h00, 3'b000, 3);
        drain(20);

`ifdef ALU_ARB_TIMEOUT_EN
        // ALU never answers: watchdog aborts after 4 WAIT cycles.
        gnt_q.push_back(1'b1);
        exp_done(1'b1, 16'hFFFF, 1'b1);
        request(1'b1, 8'h01, 8'h02, 8'h03, 3'b000, 0);
        drain(40);
        check("timeout_latency", last_dur, 5);
`else
        // Long ALU: no watchdog, result arrives intact.
        gnt_q.push_back(1'b0);
        exp_done(1'b0, 16'h5A3C, 1'b0);
        request(1'b0, 8'h5A, 8'h3C, 8'h00, 3'b001, 300);
        drain(400);
        check("latency_300", last_dur, 301);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
